mmio_irq_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 21 ++
 rtl/mmio_irq_responder_if.sv | 31 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/mmio_irq_responder.sv | 120 ++++++++++++
 tb/tb_mmio_irq_responder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: address map, interrupt vectors, STATUS layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mmio_pkg;

  localparam logic [63:0] ADDR_ART    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] ADDR_STATUS = 64'h0000_0000_8000_0008;
  localparam logic [63:0] ADDR_KEY    = 64'h0000_0000_8000_0010;

  localparam logic [3:0] IRQ_NONE = 4'd0;
  localparam logic [3:0] IRQ_KEY  = 4'd1;

  // STATUS register layout
  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_OVERFLOW  = 2;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;
  localparam int ST_COUNT_W      = 4;

endpackage

// File: rtl/mmio_irq_responder_if.sv
// Bundle of keyboard, TX byte stream, core bus and interrupt signals for the MMIO responder.
// Latency: n/a (wiring only).
// Backpressure: kbd_ready / tx_ready carry the valid-ready handshakes.
// Ports: master = core/board side, slave = responder.
interface mmio_irq_responder_if;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_done;

  modport master (
    output kbd_valid, kbd_data, tx_ready, bus_address, bus_write_data,
           bus_write_enable, bus_read_enable, interrupt_done,
    input  kbd_ready, tx_valid, tx_data, bus_read_data, interrupt_vector
  );

  modport slave (
    input  kbd_valid, kbd_data, tx_ready, bus_address, bus_write_data,
           bus_write_enable, bus_read_enable, interrupt_done,
    output kbd_ready, tx_valid, tx_data, bus_read_data, interrupt_vector
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is the oldest entry (0 when empty).
// Latency: a pushed word is visible at head one cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
// Ports: clk, reset (async active-low), push/din, pop, full, empty, count, head.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_irq_responder.sv
// MMIO responder: keyboard RX FIFO with key interrupt, STATUS/KEY reads, ART writes to a TX byte stream.
// Latency: zero-wait combinational reads; interrupt_vector registered one cycle behind FIFO state.
// Backpressure: kbd_ready drops when RX is full (extra bytes set overflow); ART writes to a full TX FIFO are dropped.
// Ports: clk, reset (async active-low), io (mmio_irq_responder_if.slave: kbd, tx, bus, interrupt).
module mmio_irq_responder
  import mmio_pkg::*;
#(
  parameter int KEY_DEPTH = 8,
  parameter int TX_DEPTH  = 8,
  parameter int HOLDOFF   = 2
) (
  input  logic clk,
  input  logic reset,
  mmio_irq_responder_if.slave io
);

  localparam int RAW = $clog2(KEY_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int HW  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic           rx_full, rx_empty;
  logic [RAW:0]   rx_count;
  logic [7:0]     rx_head;
  logic           tx_full, tx_empty;
  logic [TAW:0]   tx_count;
  logic [7:0]     tx_head;

  logic           sel_art, sel_status, sel_key;
  logic           key_pop, status_rd, art_push, tx_pop;
  logic           overflow_set;
  logic           rx_overflow;
  logic [HW-1:0]  holdoff;
  logic [3:0]     irq_q;
  logic [63:0]    status_word;
  logic [63:0]    read_mux;
  logic           unused_wdata;

  assign unused_wdata = ^io.bus_write_data[63:8];

  // Full 64-bit decode so aliases above bit 31 never hit a register.
  assign sel_art    = (io.bus_address == ADDR_ART);
  assign sel_status = (io.bus_address == ADDR_STATUS);
  assign sel_key    = (io.bus_address == ADDR_KEY);

  assign key_pop   = io.bus_read_enable && sel_key && !rx_empty;
  assign status_rd = io.bus_read_enable && sel_status;
  // Full is judged before any same-edge pop, so a push into a full TX FIFO is lost.
  assign art_push  = io.bus_write_enable && sel_art && !tx_full;
  assign tx_pop    = !tx_empty && io.tx_ready;
  // A same-edge KEY pop makes room, so that byte is not an overflow.
  assign overflow_set = io.kbd_valid && rx_full && !key_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(KEY_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (io.kbd_valid),
    .din   (io.kbd_data),
    .pop   (key_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (art_push),
    .din   (io.bus_write_data[7:0]),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_RX_NONEMPTY] = !rx_empty;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_RX_OVERFLOW] = rx_overflow;
    status_word[ST_RX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(rx_count);
    status_word[ST_TX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(tx_count);
  end

  always_comb begin
    read_mux = '0;
    if (io.bus_read_enable) begin
      if (sel_status)   read_mux = status_word;
      else if (sel_key) read_mux = {56'b0, rx_head};
    end
  end

  // Sticky overflow: a new overflow on the same edge as a STATUS read survives,
  // since that read reported the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            rx_overflow <= 1'b0;
    else if (overflow_set) rx_overflow <= 1'b1;
    else if (status_rd)    rx_overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  holdoff <= '0;
    else if (io.interrupt_done)  holdoff <= HW'(HOLDOFF);
    else if (holdoff != '0)      holdoff <= holdoff - HW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               irq_q <= IRQ_NONE;
    else if (!rx_empty && (holdoff == '0))    irq_q <= IRQ_KEY;
    else                                      irq_q <= IRQ_NONE;
  end

  assign io.kbd_ready        = !rx_full;
  assign io.tx_valid         = !tx_empty;
  assign io.tx_data          = tx_head;
  assign io.bus_read_data    = read_mux;
  assign io.interrupt_vector = irq_q;

endmodule

// File: tb/tb_mmio_irq_responder.sv
// Self-checking bench for mmio_irq_responder: vector table, directed corner sequences, randomized traffic vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mmio_irq_responder;
  import mmio_pkg::*;

  localparam int KD = 8;
  localparam int TD = 8;
  localparam int HO = 2;
  localparam logic [63:0] ADDR_NONE = 64'h0000_0000_8000_0020;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mmio_irq_responder_if ifc();

  mmio_irq_responder #(.KEY_DEPTH(KD), .TX_DEPTH(TD), .HOLDOFF(HO)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: plain queues plus a few scalars.
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit m_ovf;
  int m_hold;
  int m_irq;
  logic g_tr;

  typedef struct {
    logic [63:0] a;
    logic        we;
    logic [7:0]  wd;
    logic        re;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_rdata(input logic [63:0] a);
    longint v;
    v = 0;
    if (a == ADDR_KEY && rxq.size() > 0) v = rxq[0];
    else if (a == ADDR_STATUS)
      v = (rxq.size() > 0 ? 1 : 0) + 2 * (txq.size() == TD ? 1 : 0) + 4 * m_ovf
          + 256 * rxq.size() + 65536 * txq.size();
    return 64'(v);
  endfunction

  task automatic model_clear();
    rxq.delete();
    txq.delete();
    m_ovf = 0;
    m_hold = 0;
    m_irq = 0;
  endtask

  // One bus cycle: drive at negedge, check every output against the model, advance the model.
  task automatic cyc(input logic kv, input logic [7:0] kd, input logic [63:0] a, input logic we,
                     input logic [7:0] wd, input logic re, input logic dn, output logic [63:0] rd);
    int rs, ts;
    bit kpop, sread, art, tpop;
    @(negedge clk);
    ifc.kbd_valid = kv;
    ifc.kbd_data = kd;
    ifc.tx_ready = g_tr;
    ifc.bus_address = a;
    ifc.bus_write_enable = we;
    ifc.bus_write_data = {$urandom, 24'h0, wd};
    ifc.bus_read_enable = re;
    ifc.interrupt_done = dn;
    #1;
    rd = ifc.bus_read_data;
    rs = rxq.size();
    ts = txq.size();
    check("kbd_ready", 64'(ifc.kbd_ready), 64'(rs < KD));
    check("tx_valid", 64'(ifc.tx_valid), 64'(ts > 0));
    check("tx_data", 64'(ifc.tx_data), ts > 0 ? 64'(txq[0]) : 64'h0);
    check("irq", 64'(ifc.interrupt_vector), 64'(m_irq));
    check("rdata", rd, re ? model_rdata(a) : 64'h0);
    kpop = re && a == ADDR_KEY && rs > 0;
    sread = re && a == ADDR_STATUS;
    art = we && a == ADDR_ART && ts < TD;
    tpop = ts > 0 && g_tr;
    m_irq = (rs > 0 && m_hold == 0) ? 1 : 0;
    m_hold = dn ? HO : (m_hold > 0 ? m_hold - 1 : 0);
    if (kpop) void'(rxq.pop_front());
    if (sread) m_ovf = 0;
    if (kv) begin
      if (rs < KD || kpop) rxq.push_back(kd);
      else m_ovf = 1;
    end
    if (tpop) void'(txq.pop_front());
    if (art) txq.push_back(wd);
    @(posedge clk);
  endtask

  task automatic idle();
    logic [63:0] rd;
    cyc(0, 8'h0, 64'h0, 0, 8'h0, 0, 0, rd);
  endtask

  task automatic kbd(input logic [7:0] b);
    logic [63:0] rd;
    cyc(1, b, 64'h0, 0, 8'h0, 0, 0, rd);
  endtask

  task automatic art_wr(input logic [7:0] b);
    logic [63:0] rd;
    cyc(0, 8'h0, ADDR_ART, 1, b, 0, 0, rd);
  endtask

  task automatic bus_rd(input logic [63:0] a, output logic [63:0] rd);
    cyc(0, 8'h0, a, 0, 8'h0, 1, 0, rd);
  endtask

  task automatic drain_rx();
    logic [63:0] rd;
    for (int i = 0; i < KD + 2; i++) bus_rd(ADDR_KEY, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int n, zeros;
    logic [3:0] last_irq;

    ifc.kbd_valid = 0; ifc.kbd_data = 0; ifc.tx_ready = 0;
    ifc.bus_address = 0; ifc.bus_write_data = 0;
    ifc.bus_write_enable = 0; ifc.bus_read_enable = 0; ifc.interrupt_done = 0;
    g_tr = 0;
    model_clear();

    // Reset state
    #3;
    check("rst_kbd_ready", 64'(ifc.kbd_ready), 64'h1);
    check("rst_tx_valid", 64'(ifc.tx_valid), 64'h0);
    check("rst_tx_data", 64'(ifc.tx_data), 64'h0);
    check("rst_rdata", ifc.bus_read_data, 64'h0);
    check("rst_irq", 64'(ifc.interrupt_vector), 64'h0);
    @(negedge clk);
    reset = 1;

    // Vector table: decode, write-only/read-only registers, aliases, tx_count
    tbl[0]  = '{ADDR_STATUS, 0, 8'h00, 1, 64'h0};
    tbl[1]  = '{ADDR_ART, 1, 8'h61, 0, 64'h0};
    tbl[2]  = '{ADDR_ART, 1, 8'h62, 0, 64'h0};
    tbl[3]  = '{ADDR_STATUS, 0, 8'h00, 1, 64'h0000_0000_0002_0000};
    tbl[4]  = '{ADDR_NONE, 0, 8'h00, 1, 64'h0};
    tbl[5]  = '{ADDR_KEY, 0, 8'h00, 1, 64'h0};
    tbl[6]  = '{ADDR_ART, 0, 8'h00, 1, 64'h0};
    tbl[7]  = '{64'h0000_0001_8000_0000, 1, 8'h63, 0, 64'h0};
    tbl[8]  = '{ADDR_STATUS, 0, 8'h00, 1, 64'h0000_0000_0002_0000};
    tbl[9]  = '{ADDR_STATUS, 1, 8'h70, 1, 64'h0000_0000_0002_0000};
    tbl[10] = '{ADDR_ART, 1, 8'h64, 1, 64'h0};
    tbl[11] = '{ADDR_STATUS, 0, 8'h00, 1, 64'h0000_0000_0003_0000};
    for (int i = 0; i < 12; i++) begin
      cyc(0, 8'h0, tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].re, 0, rd);
      check($sformatf("vec%0d", i), rd, tbl[i].exp);
    end
    #1;
    check("tx_valid_held", 64'(ifc.tx_valid), 64'h1);
    check("tx_head_held", 64'(ifc.tx_data), 64'h61);
    g_tr = 1;
    idle(); #1; check("tx_byte2", 64'(ifc.tx_data), 64'h62);
    idle(); #1; check("tx_byte3", 64'(ifc.tx_data), 64'h64);
    idle(); #1; check("tx_drained", 64'(ifc.tx_valid), 64'h0);
    g_tr = 0;

    // Single key: interrupt latency, KEY read, vector drop
    kbd(8'h41);
    #1;
    n = 0;
    while (ifc.interrupt_vector != IRQ_KEY && n < 4) begin
      idle(); #1; n++;
    end
    check("irq_within_2", 64'(ifc.interrupt_vector == IRQ_KEY && n <= 2), 64'h1);
    bus_rd(ADDR_KEY, rd);   check("key_41", rd, 64'h41);
    bus_rd(ADDR_STATUS, rd); check("status_bit0_clear", rd & 64'h1, 64'h0);
    #1; check("irq_dropped", 64'(ifc.interrupt_vector), 64'h0);

    // Overflow: nine bytes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      kbd(8'(i));
      #1;
      if (i == 8) check("kbd_ready_full", 64'(ifc.kbd_ready), 64'h0);
    end
    bus_rd(ADDR_STATUS, rd); check("status_overflow", rd, 64'h805);
    bus_rd(ADDR_STATUS, rd); check("status_ovf_cleared", rd, 64'h801);
    for (int i = 1; i <= 8; i++) begin
      bus_rd(ADDR_KEY, rd);
      check($sformatf("key_order%0d", i), rd, 64'(i));
    end

    // TX full: push on the same edge as a pop is dropped
    for (int i = 0; i < 8; i++) art_wr(8'(8'h80 + i));
    bus_rd(ADDR_STATUS, rd); check("status_tx_full", rd, 64'h0008_0002);
    g_tr = 1;
    art_wr(8'h99);
    g_tr = 0;
    bus_rd(ADDR_STATUS, rd); check("tx_push_dropped", rd, 64'h0007_0000);
    g_tr = 1;
    for (int i = 0; i < 8; i++) idle();
    g_tr = 0;
    bus_rd(ADDR_STATUS, rd); check("tx_empty_after", rd, 64'h0);

    // Holdoff after interrupt_done
    kbd(8'h31); kbd(8'h32); kbd(8'h33);
    idle(); idle();
    #1; check("irq_before_done", 64'(ifc.interrupt_vector), 64'h1);
    cyc(0, 8'h0, 64'h0, 0, 8'h0, 0, 1, rd);
    zeros = 0;
    for (int i = 0; i < 6; i++) begin
      #1; if (ifc.interrupt_vector == IRQ_NONE) zeros++;
      last_irq = ifc.interrupt_vector;
      idle();
    end
    check("holdoff_zero_cycles", 64'(zeros), 64'(HO));
    check("irq_reasserted", 64'(last_irq), 64'h1);
    // Second done while holdoff is running reloads it
    cyc(0, 8'h0, 64'h0, 0, 8'h0, 0, 1, rd);
    cyc(0, 8'h0, 64'h0, 0, 8'h0, 0, 1, rd);
    zeros = 0;
    for (int i = 0; i < 6; i++) begin
      #1; if (ifc.interrupt_vector == IRQ_NONE) zeros++;
      idle();
    end
    check("holdoff_reload_zeros", 64'(zeros), 64'(HO + 1));
    drain_rx();

    // Full RX with simultaneous push and KEY pop
    for (int i = 0; i < 8; i++) kbd(8'(8'h10 + i));
    cyc(1, 8'h18, ADDR_KEY, 0, 8'h0, 1, 0, rd);
    check("full_pushpop_key", rd, 64'h10);
    bus_rd(ADDR_STATUS, rd); check("full_pushpop_status", rd, 64'h801);
    for (int i = 1; i <= 8; i++) begin
      bus_rd(ADDR_KEY, rd);
      check($sformatf("pushpop_order%0d", i), rd, 64'(8'h10 + i));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [63:0] a;
      case ($urandom_range(0, 4))
        0: a = ADDR_ART;
        1: a = ADDR_STATUS;
        2, 3: a = ADDR_KEY;
        default: a = {$urandom, $urandom};
      endcase
      g_tr = ($urandom_range(0, 2) == 0);
      cyc(logic'($urandom_range(0, 9) < 6), 8'($urandom), a, logic'($urandom_range(0, 1)),
          8'($urandom), logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 15) == 0), rd);
    end

    // Reset in the middle of a TX transfer with an interrupt pending
    g_tr = 0;
    drain_rx();
    for (int i = 0; i < 4; i++) art_wr(8'(8'hA0 + i));
    kbd(8'h55);
    idle(); idle();
    g_tr = 1;
    idle();
    @(negedge clk);
    #2 reset = 0;
    #1;
    check("midrst_tx_valid", 64'(ifc.tx_valid), 64'h0);
    check("midrst_tx_data", 64'(ifc.tx_data), 64'h0);
    check("midrst_irq", 64'(ifc.interrupt_vector), 64'h0);
    check("midrst_kbd_ready", 64'(ifc.kbd_ready), 64'h1);
    model_clear();
    g_tr = 0;
    @(negedge clk);
    reset = 1;
    bus_rd(ADDR_STATUS, rd); check("post_rst_status", rd, 64'h0);
    bus_rd(ADDR_NONE, rd);   check("post_rst_unmapped", rd, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
